score_display_driver: RTL

- Consumes the processor's 32-bit score word (`score_out`) and drives a 4-digit multiplexed 7-segment display.
- Each new score value is converted from binary to BCD with a sequential double-dabble engine.
- Sits outside `processor_skeleton`, on the board side of the score output.

---
 rtl/score_display_driver.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/score_display_driver.sv
// Score display driver: clamps the processor score word, converts it to BCD
// with a sequential double-dabble engine, and scans a 4-digit 7-segment display.
module score_display_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             score_in,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    busy,
   output logic                    ovf
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int BIN_W  = 14;
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [3:0]       LAST_ITER    = 4'd13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [31:0]          r_captured;
   logic [BIN_W-1:0]     r_bin;
   logic [BCD_W-1:0]     r_acc;
   logic [3:0]           r_cnt;
   logic                 r_ovf_pend;
   logic [BCD_W-1:0]     r_bcd;
   logic                 r_ovf;
   logic                 r_busy;

   logic [CNT_W-1:0]     r_refresh;
   logic [IDX_W-1:0]     r_idx;
   logic [NUM_DIGITS-1:0] r_an;

   logic [BIN_W-1:0]     w_clamp_val;
   logic                 w_clamp_ovf;
   logic [BCD_W-1:0]     w_adj;
   logic [IDX_W-1:0]     w_idx_next;
   logic [BCD_W-1:0]     w_upper;
   logic                 w_blank;
   logic [6:0]           w_seg_n;
   logic                 w_dp_n;

   // Negative scores show 0 and anything above 9999 saturates; both raise the clamp flag.
   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the missing case.
   always_comb begin
      w_clamp_val = score_in[BIN_W-1:0];
      w_clamp_ovf = 1'b0;
      if (score_in[31]) begin
         w_clamp_val = '0;
         w_clamp_ovf = 1'b1;
      end else if (score_in > 32'd9999) begin
         w_clamp_val = BIN_W'(9999);
         w_clamp_ovf = 1'b1;
      end
   end

   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_captured <= '0;
         r_bin      <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_bcd      <= '0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (score_in != r_captured) begin
                  r_captured <= score_in;
                  r_bin      <= w_clamp_val;
                  r_ovf_pend <= w_clamp_ovf;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= CONV;
                  r_busy     <= 1'b1;
               end
            end
            CONV: begin
               r_acc <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_bcd   <= r_acc;
               r_ovf   <= r_ovf_pend;
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign w_idx_next = r_idx + IDX_W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_refresh <= '0;
         r_idx     <= '0;
         r_an      <= ~NUM_DIGITS'(1);
      end else if (r_refresh == REFRESH_LAST) begin
         r_refresh <= '0;
         r_idx     <= w_idx_next;
         r_an      <= ~(NUM_DIGITS'(1) << w_idx_next);
      end else begin
         r_refresh <= r_refresh + CNT_W'(1);
      end
   end

   // A digit is blank when it and every more significant digit are zero.
   assign w_upper = r_bcd >> {r_idx, 2'b00};
   assign w_blank = (r_idx != '0) && (w_upper == '0);

   always_comb begin
      w_seg_n = 7'h7F;
      if (!w_blank) begin
         case (w_upper[3:0])
            4'd0:    w_seg_n = 7'h40;
            4'd1:    w_seg_n = 7'h79;
            4'd2:    w_seg_n = 7'h24;
            4'd3:    w_seg_n = 7'h30;
            4'd4:    w_seg_n = 7'h19;
            4'd5:    w_seg_n = 7'h12;
            4'd6:    w_seg_n = 7'h02;
            4'd7:    w_seg_n = 7'h78;
            4'd8:    w_seg_n = 7'h00;
            4'd9:    w_seg_n = 7'h10;
            default: w_seg_n = 7'h7F;
         endcase
      end
   end

   assign w_dp_n = ~(r_ovf && (r_idx == '0));

   assign seg_n = w_seg_n;
   assign dp_n  = w_dp_n;
   assign an_n  = r_an;
   assign bcd   = r_bcd;
   assign busy  = r_busy;
   assign ovf   = r_ovf;

endmodule
